// File: rtl/hazard_scoreboard.sv
// Purpose : operand-hazard scoreboard beside decode; tracks {v, rd, we, ld} of every post-decode stage.
// Latency : fwd_sel/stall are combinational from stage state and decode inputs; state shifts every edge.
// Backpr. : stall=1 holds fetch/decode and loads a bubble into stage 0; flush kills the EX and decode slots.
//
// Ports:
//   clk, arst                  pipeline clock (rising edge), asynchronous active-high reset
//   issue_valid/rd/reg_write/is_load   decoding instruction's destination information
//   flush                      kill the stage-0 (EX) instruction and the decoding instruction
//   src_reg/src_used           per-operand source register (k*REG_AW +: REG_AW) and read enable
//   fwd_sel                    per operand (k*SELW +: SELW): 0 = register file, i+1 = stage i
//   stall                      load-use hazard on the youngest producer of any used operand
//   stall_count                saturating count of non-flushed stall cycles
//
// Build option: define HAZARD_STATS_EN to build the stall counter; otherwise stall_count reads 0.
module hazard_scoreboard #(
    parameter int  NUM_SRC    = 2,
    parameter int  DEPTH      = 3,
    parameter int  REG_AW     = 5,
    parameter int  LOAD_READY = 2,
    localparam int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_reg_write,
    input  logic                      issue_is_load,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    input  logic [NUM_SRC-1:0]        src_used,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_count
);

    // One tracked pipeline slot.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } entry_t;

    entry_t stage_q [DEPTH];
    entry_t stage_d [DEPTH];

    logic [NUM_SRC-1:0] src_stall;

    // Hazard resolution. Stages are scanned oldest to youngest so that the
    // youngest matching writer is the last one to assign, shadowing older
    // matches for both the forwarding select and the load-use decision.
    always_comb begin
        fwd_sel   = '0;
        src_stall = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (stage_q[i].v && stage_q[i].we && src_used[k] &&
                    (stage_q[i].rd != '0) &&
                    (stage_q[i].rd == src_reg[k*REG_AW +: REG_AW])) begin
                    fwd_sel[k*SELW +: SELW] = SELW'(i + 1);
                    // Load data only exists from LOAD_READY onward.
                    src_stall[k] = stage_q[i].ld && (i < LOAD_READY);
                end
            end
        end
    end

    assign stall = |src_stall;

    // Next stage contents: plain shift with no hold. A stalled or flushed
    // decode enters stage 0 as a bubble; flush also kills the EX instruction
    // on its way into stage 1.
    always_comb begin
        for (int i = DEPTH - 1; i > 0; i--) begin
            stage_d[i] = stage_q[i-1];
        end
        stage_d[0] = '{v:  issue_valid && !stall && !flush,
                       rd: issue_rd,
                       we: issue_reg_write,
                       ld: issue_is_load};
        if (flush) begin
            stage_d[1].v = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // A stall coinciding with flush is not a real load-use penalty, so it is
    // not counted. The counter sticks at all-ones.
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : self-checking bench for hazard_scoreboard against an issue-history reference model.
// Latency : outputs compared every negedge against the model; model history advances every posedge.
// Backpr. : bench re-presents a stalled decode instruction, as the real decode stage would.
module tb_hazard_scoreboard;

    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 3;
    localparam int REG_AW     = 5;
    localparam int LOAD_READY = 2;
    localparam int SELW       = $clog2(DEPTH + 1);
    localparam int HIST       = 4096;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      arst = 1'b1;
    logic                      issue_valid = 1'b0;
    logic [REG_AW-1:0]         issue_rd = '0;
    logic                      issue_reg_write = 1'b0;
    logic                      issue_is_load = 1'b0;
    logic                      flush = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] src_reg = '0;
    logic [NUM_SRC-1:0]        src_used = '0;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic [15:0]               stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC   (NUM_SRC),
        .DEPTH     (DEPTH),
        .REG_AW    (REG_AW),
        .LOAD_READY(LOAD_READY)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_reg_write(issue_reg_write),
        .issue_is_load  (issue_is_load),
        .flush          (flush),
        .src_reg        (src_reg),
        .src_used       (src_used),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .stall_count    (stall_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a history of what decode handed to the pipeline in
    // each cycle. During cycle c, the instruction accepted in cycle c-a sits
    // a-1 stages past decode, so the answer is a search over the last DEPTH
    // accepted instructions, youngest first.
    bit              rec_v  [HIST];
    bit [REG_AW-1:0] rec_rd [HIST];
    bit              rec_we [HIST];
    bit              rec_ld [HIST];
    int              cyc     = 0;
    int              floor_c = 0;   // history before this index was wiped by reset
    int              exp_cnt = 0;
    int              exp_sel [NUM_SRC];
    bit              exp_stall = 1'b0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void model_eval();
        exp_stall = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [REG_AW-1:0] s;
            s = src_reg[k*REG_AW +: REG_AW];
            exp_sel[k] = 0;
            for (int age = 1; age <= DEPTH; age++) begin
                int idx;
                idx = cyc - age;
                if (idx >= floor_c && idx >= 0 && src_used[k] && rec_v[idx] &&
                    rec_we[idx] && rec_rd[idx] != 0 && rec_rd[idx] == s) begin
                    exp_sel[k] = age;
                    if (rec_ld[idx] && (age - 1) < LOAD_READY) exp_stall = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic int exp_count();
        return STATS ? exp_cnt : 0;
    endfunction

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        model_eval();
        for (int k = 0; k < NUM_SRC; k++) begin
            check($sformatf("model.fwd_sel[%0d]", k), 32'(fwd_sel[k*SELW +: SELW]), exp_sel[k]);
        end
        check("model.stall", 32'(stall), 32'(exp_stall));
        check("model.stall_count", 32'(stall_count), exp_count());
    end

    // Model history update at each edge.
    always @(posedge clk) begin
        if (cyc < HIST) begin
            rec_v[cyc]  = !arst && issue_valid && !exp_stall && !flush;
            rec_rd[cyc] = issue_rd;
            rec_we[cyc] = issue_reg_write;
            rec_ld[cyc] = issue_is_load;
            if (flush && !arst && cyc > 0) rec_v[cyc-1] = 1'b0;
        end
        if (!arst && exp_stall && !flush && exp_cnt < 65535) exp_cnt++;
        cyc++;
    end

    always @(posedge arst) begin
        floor_c = cyc;
        exp_cnt = 0;
    end

    task automatic drive(input bit v, input int rd, input bit we, input bit ld,
                         input int s0, input bit u0, input int s1, input bit u1, input bit fl);
        @(posedge clk);
        #1;
        issue_valid     = v;
        issue_rd        = REG_AW'(rd);
        issue_reg_write = we;
        issue_is_load   = ld;
        src_reg         = {REG_AW'(s1), REG_AW'(s0)};
        src_used        = {u1, u0};
        flush           = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_now(input string name, input int sel0, input int sel1, input bit st);
        @(negedge clk);
        #1;
        check({name, ".sel0"}, 32'(fwd_sel[SELW-1:0]), sel0);
        check({name, ".sel1"}, 32'(fwd_sel[2*SELW-1:SELW]), sel1);
        check({name, ".stall"}, 32'(stall), 32'(st));
    endtask

    initial begin
        // Reset state.
        expect_now("reset", 0, 0, 0);
        check("reset.count", 32'(stall_count), 0);
        @(posedge clk);
        #1 arst = 1'b0;
        idle(2);

        // ALU chain: add x5 then consumers of x5 at t+1..t+4.
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("alu_t1", 1, 0, 0);
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("alu_t2", 2, 0, 0);
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("alu_t3", 3, 0, 0);
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0); expect_now("alu_t4", 0, 0, 0);
        idle(4);

        // Load-use: the load is in stage 0 then stage 1, both short of
        // LOAD_READY, so the held consumer stalls twice and then takes stage 2.
        drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 8, 1, 0, 7, 1, 0, 0, 0); expect_now("ld_t1", 1, 0, 1);
        drive(1, 8, 1, 0, 7, 1, 0, 0, 0); expect_now("ld_t2", 2, 0, 1);
        drive(1, 8, 1, 0, 7, 1, 0, 0, 0); expect_now("ld_t3", 3, 0, 0);
        check("ld.count", 32'(stall_count), STATS ? 2 : 0);
        // Only the accepted copy of the consumer is in flight: one stage deep.
        drive(1, 0, 0, 0, 8, 1, 7, 1, 0); expect_now("ld_t4", 1, 0, 0);
        idle(4);

        // Youngest wins, then x0 never forwards.
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 3, 1, 0, 0, 0); expect_now("youngest", 1, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0); expect_now("x0", 0, 0, 0);
        idle(4);

        // Unused operand ignores a pending load; the same register used does stall.
        drive(1, 9, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 9, 0, 0); expect_now("unused", 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 9, 1, 0); expect_now("used", 0, 2, 1);
        idle(4);

        // Flush during a load-use stall: both lw and the dependent die, no count.
        drive(1, 4, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 6, 1, 0, 4, 1, 0, 0, 1); expect_now("flush_stall", 1, 0, 1);
        drive(1, 0, 0, 0, 4, 1, 6, 1, 0); expect_now("flush_after", 0, 0, 0);
        check("flush.count", 32'(stall_count), STATS ? 3 : 0);
        idle(4);

        // Randomized traffic; a stalled decode is held unless flushed.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            if (n == 703) arst = 1'b0;
            if (exp_stall && !flush) begin
                flush = ($urandom_range(0, 19) == 0);
            end else begin
                issue_valid     = ($urandom_range(0, 3) != 0);
                issue_rd        = REG_AW'($urandom_range(0, 7));
                issue_reg_write = ($urandom_range(0, 3) != 0);
                issue_is_load   = ($urandom_range(0, 2) == 0);
                src_reg         = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
                src_used        = NUM_SRC'($urandom_range(0, 3));
                flush           = ($urandom_range(0, 19) == 0);
            end
            if (n == 700) begin
                #2 arst = 1'b1;
            end
        end
        idle(4);

        // Async reset between edges with three valid producers in flight.
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 11, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 10, 1, 12, 1, 0);
        #2 arst = 1'b1;
        expect_now("arst_mid", 0, 0, 0);
        check("arst.count", 32'(stall_count), 0);
        @(posedge clk);
        #1 arst = 1'b0;
        drive(1, 0, 0, 0, 11, 1, 10, 1, 0); expect_now("arst_after", 0, 0, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
